// File: rtl/mem_port_arbiter_pkg.sv
// Memory port types shared by the core, the DMA/debug master and the MMU.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;

    typedef logic [3:0] mem_exception_mask_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-master, one-transaction-at-a-time arbiter in front of the single memory port.
// Requester 0 has fixed priority; a burst counter lets requester 1 in after MAX_BURST grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,

    input  logic                req0_valid,
    input  logic [31:0]         req0_addr,
    input  logic [31:0]         req0_wr_data,
    input  logic                req0_wr_ena,
    input  mem_access_t         req0_access,
    output logic                req0_ready,
    output logic                req0_resp_valid,
    output logic [31:0]         req0_rd_data,
    output mem_exception_mask_t req0_exception,

    input  logic                req1_valid,
    input  logic [31:0]         req1_addr,
    input  logic [31:0]         req1_wr_data,
    input  logic                req1_wr_ena,
    input  mem_access_t         req1_access,
    output logic                req1_ready,
    output logic                req1_resp_valid,
    output logic [31:0]         req1_rd_data,
    output mem_exception_mask_t req1_exception,

    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wr_data,
    output logic                mem_wr_ena,
    output mem_access_t         mem_access,
    input  logic [31:0]         mem_rd_data,
    input  mem_exception_mask_t mem_exception,

    output logic                busy
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         lat_addr_q, lat_addr_d;
    logic [31:0]         lat_wr_data_q, lat_wr_data_d;
    logic                lat_wr_ena_q, lat_wr_ena_d;
    mem_access_t         lat_access_q, lat_access_d;
    logic                lat_id_q, lat_id_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;
    mem_exception_mask_t exc_lat_q, exc_lat_d;
    logic [31:0]         rd0_data_q, rd0_data_d;
    logic [31:0]         rd1_data_q, rd1_data_d;
    mem_exception_mask_t exc0_q, exc0_d;
    mem_exception_mask_t exc1_q, exc1_d;
    logic [1:0]          resp_valid_q, resp_valid_d;

    logic                grant_valid;
    logic                grant_id;
    logic [31:0]         resp_data;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state_q == S_IDLE && ena && !rst) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = (starve_cnt_q == MAX_CNT);
            end else if (req0_valid) begin
                grant_valid = 1'b1;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign req0_ready = grant_valid && !grant_id;
    assign req1_ready = grant_valid && grant_id;

    always_comb begin
        state_d       = state_q;
        lat_addr_d    = lat_addr_q;
        lat_wr_data_d = lat_wr_data_q;
        lat_wr_ena_d  = lat_wr_ena_q;
        lat_access_d  = lat_access_q;
        lat_id_d      = lat_id_q;
        starve_cnt_d  = starve_cnt_q;
        exc_lat_d     = exc_lat_q;
        rd0_data_d    = rd0_data_q;
        rd1_data_d    = rd1_data_q;
        exc0_d        = exc0_q;
        exc1_d        = exc1_q;
        // A pending pulse survives an ena-low window and is delivered afterwards.
        resp_valid_d  = ena ? 2'b00 : resp_valid_q;
        resp_data     = lat_wr_ena_q ? 32'd0 : mem_rd_data;

        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (grant_valid) begin
                        lat_id_d      = grant_id;
                        lat_addr_d    = grant_id ? req1_addr    : req0_addr;
                        lat_wr_data_d = grant_id ? req1_wr_data : req0_wr_data;
                        lat_wr_ena_d  = grant_id ? req1_wr_ena  : req0_wr_ena;
                        lat_access_d  = grant_id ? req1_access  : req0_access;
                        state_d       = S_ISSUE;
                        if (grant_id || !req1_valid)
                            starve_cnt_d = 4'd0;
                        else if (starve_cnt_q != MAX_CNT)
                            starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end
                S_ISSUE: begin
                    exc_lat_d = mem_exception;
                    state_d   = S_RESP;
                end
                S_RESP: begin
                    if (lat_id_q) begin
                        rd1_data_d = resp_data;
                        exc1_d     = exc_lat_q;
                    end else begin
                        rd0_data_d = resp_data;
                        exc0_d     = exc_lat_q;
                    end
                    resp_valid_d[lat_id_q] = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lat_addr_q    <= 32'd0;
            lat_wr_data_q <= 32'd0;
            lat_wr_ena_q  <= 1'b0;
            lat_access_q  <= MEM_ACCESS_WORD;
            lat_id_q      <= 1'b0;
            starve_cnt_q  <= 4'd0;
            exc_lat_q     <= '0;
            rd0_data_q    <= 32'd0;
            rd1_data_q    <= 32'd0;
            exc0_q        <= '0;
            exc1_q        <= '0;
            resp_valid_q  <= 2'b00;
        end else begin
            state_q       <= state_d;
            lat_addr_q    <= lat_addr_d;
            lat_wr_data_q <= lat_wr_data_d;
            lat_wr_ena_q  <= lat_wr_ena_d;
            lat_access_q  <= lat_access_d;
            lat_id_q      <= lat_id_d;
            starve_cnt_q  <= starve_cnt_d;
            exc_lat_q     <= exc_lat_d;
            rd0_data_q    <= rd0_data_d;
            rd1_data_q    <= rd1_data_d;
            exc0_q        <= exc0_d;
            exc1_q        <= exc1_d;
            resp_valid_q  <= resp_valid_d;
        end
    end

    // The latched request stays on the port after completion until the next grant.
    assign mem_addr        = lat_addr_q;
    assign mem_wr_data     = lat_wr_data_q;
    assign mem_access      = lat_access_q;
    assign mem_wr_ena      = (state_q == S_ISSUE) && lat_wr_ena_q && ena && !rst;
    assign busy            = (state_q != S_IDLE);

    assign req0_resp_valid = resp_valid_q[0] && ena;
    assign req1_resp_valid = resp_valid_q[1] && ena;
    assign req0_rd_data    = rd0_data_q;
    assign req1_rd_data    = rd1_data_q;
    assign req0_exception  = exc0_q;
    assign req1_exception  = exc1_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter that shares the single memory port (address, write data, write enable, access size, read data, exception mask) between requester 0 (the RV32I multicycle core) and requester 1 (a DMA/debug master). The arbiter handles one transaction at a time and drives it through a fixed three-state sequence. Requester 0 has fixed priority. A burst counter bounds how long requester 1 can be starved. The block sits between the masters and the MMU/memory-map decoder.

## Interface
- MAX_BURST, 4, consecutive grants to requester 0 while requester 1 is waiting before requester 1 is forced in; legal range 1..15.
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- ena  in  1  global enable; low freezes all state
- reqN_valid  in  1  request from requester N (N = 0, 1)
- reqN_addr  in  32  byte address
- reqN_wr_data  in  32  store data
- reqN_wr_ena  in  1  1 = store, 0 = load
- reqN_access  in  mem_access_t  byte, half or word
- reqN_ready  out  1  request accepted this cycle
- reqN_resp_valid  out  1  one-cycle completion pulse (loads and stores)
- reqN_rd_data  out  32  load data, valid with resp_valid
- reqN_exception  out  mem_exception_mask_t  exception mask, valid with resp_valid
- mem_addr  out  32  to memory
- mem_wr_data  out  32  to memory
- mem_wr_ena  out  1  to memory
- mem_access  out  mem_access_t  to memory
- mem_rd_data  in  32  from memory; valid one cycle after the address is presented
- mem_exception  in  mem_exception_mask_t  from memory; combinational on address, size and write enable
- busy  out  1  high in S_ISSUE and S_RESP

## Operation
- States: S_IDLE, S_ISSUE, S_RESP.
- **S_IDLE:**
  - Arbitrate among valid requesters and assert the winner's reqN_ready combinationally.
  - At the clock edge, latch the winner's addr, wr_data, wr_ena, access and id, then go to S_ISSUE.
  - If no request is valid, stay in S_IDLE.
- **Arbitration:**
  - Only requester 0 valid: grant 0.
  - Only requester 1 valid: grant 1.
  - Both valid: grant 1 if starve_cnt == MAX_BURST, else grant 0.
- **starve_cnt (4 bits):**
  - Grant to 0 while req1_valid = 1: increment, saturating at MAX_BURST.
  - Grant to 0 while req1_valid = 0: clear.
  - Grant to 1: clear.
- **S_ISSUE:**
  - Drive mem_* from the latched request.
  - mem_wr_ena = latched wr_ena, high for exactly this cycle.
  - Register mem_exception.
  - Go to S_RESP.
- **S_RESP:**
  - mem_addr and mem_access stay held; mem_wr_ena = 0.
  - Register mem_rd_data; for stores, register 0 instead.
  - Go to S_IDLE. At that edge, set resp_valid for the latched id.
- **Response outputs:**
  - resp_valid is high only for the owner and only for one cycle.
  - rd_data and exception hold their last values until the next response.
  - The arbiter does not alter a transaction that raises an exception; it only reports the exception.
- **Requester obligations:** hold valid and payload stable until ready. Dropping valid before ready is legal and cancels the request.
- **ena low:**
  - State, latches and counter hold.
  - Both readies = 0, mem_wr_ena = 0, resp_valid = 0.
  - A pending S_ISSUE write is performed once ena returns high.

## Timing
- Reset values:
  - State: S_IDLE.
  - mem_addr = 0, mem_wr_data = 0, mem_wr_ena = 0, mem_access = MEM_ACCESS_WORD.
  - readies = 0, resp_valid = 0, rd_data = 0, exception = 0, busy = 0, starve_cnt = 0.
- Latency: ready in cycle T, S_ISSUE in T+1, S_RESP in T+2, resp_valid in T+3.
- Throughput: in cycle T+3 the arbiter is in S_IDLE and can accept the next request. A continuously valid requester therefore sees ready every 3 cycles.
- Reset mid-transaction: the transaction is dropped with no resp_valid. A write in progress completes only if its S_ISSUE cycle finished before reset.
- A request arriving during S_ISSUE or S_RESP waits; ready stays 0 until S_IDLE.

## Test plan
- **Single load:** req0 load at 0x1000_0004 word, mem_rd_data = 0xDEADBEEF in the S_RESP cycle -> ready0 at T, mem_addr = 0x1000_0004 at T+1..T+2, resp_valid0 with rd_data 0xDEADBEEF at T+3, req1 outputs untouched.
- **Store:** req1 store 0xA5 byte to 0x2000_0010 -> mem_wr_ena high only at T+1, mem_access = MEM_ACCESS_BYTE, resp_valid1 at T+3, rd_data1 = 0.
- **Starvation guard:** both held valid, MAX_BURST = 4 -> grant sequence 0,0,0,0,1,0,0,0,0,1; readies 3 cycles apart.
- **Exception:** mem_exception forced nonzero during S_ISSUE -> reqN_exception equals that mask at resp_valid.
- **ena:** ena deasserted during S_ISSUE of a store for 5 cycles -> mem_wr_ena = 0 throughout, then high for exactly one cycle after ena returns, resp_valid 2 cycles later.
- **Reset mid-op:** rst in S_RESP -> no resp_valid, all outputs at reset values next cycle, starve_cnt = 0.
